// File: rtl/rv32imc_types.sv
// Shared RV32IMC types: M-extension divide opcodes (funct3 encoding)
// and the sequential divider's FSM states.
package rv32imc_types;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    DIV  = 3'b100,
    DIVU = 3'b101,
    REM  = 3'b110,
    REMU = 3'b111
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider.sv
// Iterative RV32M divider: restoring radix-2, one quotient bit per cycle,
// stalling the pipeline while busy and presenting the result for one cycle.
module seq_divider
  import rv32imc_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start,
  input  div_op_e     div_op,
  output logic [31:0] div_out,
  output logic        div_stall,
  output logic        divide_by_0
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] rq_q, rq_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        is_rem_q, is_rem_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [31:0] out_q, out_d;
  logic        dz_q, dz_d;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  logic        op_signed, op_rem, a_neg, b_neg, b_zero, ovf;
  logic [31:0] a_mag, b_mag;
  logic [32:0] diff;
  logic [63:0] rq_step;
  logic [31:0] result;

  assign op_signed = (div_op == DIV) | (div_op == REM);
  assign op_rem    = (div_op == REM) | (div_op == REMU);
  assign a_neg     = op_signed & a[31];
  assign b_neg     = op_signed & b[31];
  assign a_mag     = neg_if(a, a_neg);
  assign b_mag     = neg_if(b, b_neg);
  assign b_zero    = (b == 32'd0);
  assign ovf       = op_signed & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);

  // rq_q[63:31] is the shifted partial remainder including its carry-out bit
  assign diff    = rq_q[63:31] - {1'b0, dvsr_q};
  assign rq_step = diff[32] ? {rq_q[62:0], 1'b0} : {diff[31:0], rq_q[30:0], 1'b1};
  assign result  = is_rem_q ? neg_if(rq_step[63:32], r_neg_q)
                            : neg_if(rq_step[31:0], q_neg_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rq_d     = rq_q;
    dvsr_d   = dvsr_q;
    is_rem_d = is_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    out_d    = out_q;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rq_d     = {32'd0, a_mag};
          dvsr_d   = b_mag;
          is_rem_d = op_rem;
          q_neg_d  = a_neg ^ b_neg;
          r_neg_d  = a_neg;
          cnt_d    = 5'd0;
          dz_d     = b_zero;
          if (b_zero) begin
            out_d   = op_rem ? a : 32'hFFFF_FFFF;
            state_d = DONE;
          end else if (ovf) begin
            out_d   = op_rem ? 32'd0 : 32'h8000_0000;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rq_d  = rq_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          out_d   = result;
          state_d = DONE;
        end
      end
      DONE: begin
        dz_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      rq_q     <= 64'd0;
      dvsr_q   <= 32'd0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      out_q    <= 32'd0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rq_q     <= rq_d;
      dvsr_q   <= dvsr_d;
      is_rem_q <= is_rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      out_q    <= out_d;
      dz_q     <= dz_d;
    end
  end

  // Stall is combinational so the requesting instruction holds in execute at once
  assign div_stall   = ~rst & (((state_q == IDLE) & start) | (state_q == BUSY));
  assign div_out     = out_q;
  assign divide_by_0 = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: transaction-level reference model checked
// every cycle, directed literal cases, then randomized traffic with reset pulses.
module tb_seq_divider;
  import rv32imc_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  div_op_e     div_op = DIVU;
  logic [31:0] div_out;
  logic        div_stall;
  logic        divide_by_0;

  int tests = 0;
  int fails = 0;

  seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .start       (start),
    .div_op      (div_op),
    .div_out     (div_out),
    .div_stall   (div_stall),
    .divide_by_0 (divide_by_0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V M-extension semantics expressed with plain arithmetic
  function automatic logic [31:0] model_result(input logic [31:0] x, input logic [31:0] y,
                                               input div_op_e op);
    logic        sgn;
    logic        want_rem;
    logic [31:0] q;
    logic [31:0] r;
    sgn      = (op == DIV) || (op == REM);
    want_rem = (op == REM) || (op == REMU);
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
    return want_rem ? r : q;
  endfunction

  function automatic bit model_special(input logic [31:0] x, input logic [31:0] y,
                                       input div_op_e op);
    bit sgn;
    sgn = (op == DIV) || (op == REM);
    return (y == 32'd0) || (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  // m_rem: -1 = idle, >0 = stall cycles still to come, 0 = result cycle
  int          m_rem = -1;
  logic [31:0] m_res = 32'd0;
  logic [31:0] m_last = 32'd0;
  logic        m_dz = 1'b0;

  always @(negedge clk) begin : cmp
    logic        e_stall;
    logic        e_dz;
    logic [31:0] e_out;
    if (rst) begin
      e_stall = 1'b0; e_out = 32'd0; e_dz = 1'b0;
      m_rem = -1; m_last = 32'd0;
    end else if (m_rem == 0) begin
      e_stall = 1'b0; e_out = m_res; e_dz = m_dz;
      m_last = m_res; m_rem = -1;
    end else if (m_rem > 0) begin
      e_stall = 1'b1; e_out = m_last; e_dz = 1'b0;
      m_rem--;
    end else begin
      e_stall = start; e_out = m_last; e_dz = 1'b0;
      if (start) begin
        m_res = model_result(a, b, div_op);
        m_dz  = (b == 32'd0);
        m_rem = model_special(a, b, div_op) ? 0 : 32;
      end
    end
    chk("model stall", {31'd0, div_stall}, {31'd0, e_stall});
    chk("model div_out", div_out, e_out);
    chk("model divide_by_0", {31'd0, divide_by_0}, {31'd0, e_dz});
  end

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic div_op_e pick_op();
    case ($urandom_range(0, 3))
      0:       return DIV;
      1:       return DIVU;
      2:       return REM;
      default: return REMU;
    endcase
  endfunction

  // Issues one operation, scrambles operands while it runs, checks literals at DONE
  task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb,
                        input div_op_e op, input logic [31:0] lit, input int lat,
                        input logic lit_dz, input bit hold);
    int n;
    @(posedge clk); #1;
    a = ta; b = tb; div_op = op; start = 1'b1;
    n = 0;
    @(negedge clk);
    while (div_stall && n < 100) begin
      n++;
      @(posedge clk); #1;
      a = $urandom; b = $urandom; div_op = pick_op();
      @(negedge clk);
    end
    chk({name, " latency"}, 32'(n), 32'(lat));
    chk({name, " result"}, div_out, lit);
    chk({name, " divide_by_0"}, {31'd0, divide_by_0}, {31'd0, lit_dz});
    if (!hold) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; a = 32'd5; b = 32'd0; div_op = DIVU;
    repeat (3) @(posedge clk);
    #1;
    chk("reset stall", {31'd0, div_stall}, 32'd0);
    chk("reset div_out", div_out, 32'd0);
    chk("reset divide_by_0", {31'd0, divide_by_0}, 32'd0);
    rst = 1'b0; start = 1'b0;

    run_op("DIVU 100/7", 32'd100, 32'd7, DIVU, 32'd14, 33, 1'b0, 1'b0);

    @(posedge clk); #1;
    a = 32'd1000; b = 32'd3; div_op = DIVU; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid-busy reset stall", {31'd0, div_stall}, 32'd0);
    chk("mid-busy reset div_out", div_out, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    run_op("DIVU 1000/3 after reset", 32'd1000, 32'd3, DIVU, 32'd333, 33, 1'b0, 1'b0);

    run_op("REMU 100/7", 32'd100, 32'd7, REMU, 32'd2, 33, 1'b0, 1'b0);
    run_op("DIV -7/2", 32'hFFFF_FFF9, 32'd2, DIV, 32'hFFFF_FFFD, 33, 1'b0, 1'b0);
    run_op("REM -7/2", 32'hFFFF_FFF9, 32'd2, REM, 32'hFFFF_FFFF, 33, 1'b0, 1'b0);
    run_op("DIVU x/0", 32'h1234, 32'd0, DIVU, 32'hFFFF_FFFF, 1, 1'b1, 1'b0);
    run_op("REMU x/0", 32'h1234, 32'd0, REMU, 32'h1234, 1, 1'b1, 1'b0);
    run_op("DIV overflow", 32'h8000_0000, 32'hFFFF_FFFF, DIV, 32'h8000_0000, 1, 1'b0, 1'b0);
    run_op("REM overflow", 32'h8000_0000, 32'hFFFF_FFFF, REM, 32'd0, 1, 1'b0, 1'b0);
    run_op("b2b DIVU 100/7", 32'd100, 32'd7, DIVU, 32'd14, 33, 1'b0, 1'b1);
    run_op("b2b REMU 50/8", 32'd50, 32'd8, REMU, 32'd2, 33, 1'b0, 1'b0);

    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #1;
      start  = ($urandom_range(0, 3) != 0);
      a      = pick_val();
      b      = pick_val();
      div_op = pick_op();
      rst    = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
